// File: rtl/ldm_scan_ctrl.sv
// LED dot-matrix scan controller: frame buffer, serial column shift, row latch
// and brightness-weighted row enable. All outputs come straight from flops.
//
// state     | meaning
// S_IDLE    | scan stopped, all outputs low, row counter at 0
// S_SHIFT   | shifting current row out on LDM_CLK/LDM_DATA, MSB first
// S_LATCH   | one-cycle latch pulse, row address presented, brightness sampled
// S_DISPLAY | row lit for bright*ON_UNIT of the 15*ON_UNIT window
module ldm_scan_ctrl #(
    parameter int ROWS    = 16,
    parameter int ADDR_W  = 4,
    parameter int COLS    = 16,
    parameter int DIV     = 2,
    parameter int ON_UNIT = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              en,
    input  logic [3:0]        bright,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_row,
    input  logic [COLS-1:0]   wr_data,
    output logic              LDM_CLK,
    output logic              LDM_DATA,
    output logic              LDM_LATCH,
    output logic              LDM_ADDR_EN,
    output logic [ADDR_W-1:0] LDM_ADDR,
    output logic              frame_done
);

    localparam int SHIFT_TC = 2 * DIV - 1;
    localparam int DISP_TC  = 15 * ON_UNIT - 1;
    localparam int TMR_MAX  = (SHIFT_TC > DISP_TC) ? SHIFT_TC : DISP_TC;
    localparam int TMR_W    = $clog2(TMR_MAX + 1);
    localparam int BIT_W    = (COLS > 1) ? $clog2(COLS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_LATCH, S_DISPLAY} state_t;

    state_t              state, state_n;
    logic [ADDR_W-1:0]   row, row_n;
    logic [BIT_W-1:0]    bit_cnt, bit_n;
    logic [TMR_W-1:0]    tmr, tmr_n;
    logic [COLS-1:0]     shreg, shreg_n;
    logic [3:0]          bright_q, bright_n;
    logic [COLS-1:0]     fb [ROWS];

    logic                clk_q, clk_n;
    logic                data_q, data_n;
    logic                latch_q, latch_n;
    logic                aen_q, aen_n;
    logic [ADDR_W-1:0]   addr_q, addr_n;
    logic                done_q, done_n;

    // Lit while still inside the first b*ON_UNIT cycles of the down-counting window.
    function automatic logic lit(input logic [TMR_W-1:0] t, input logic [3:0] b);
        return int'(t) >= (15 - int'(b)) * ON_UNIT;
    endfunction

    always_comb begin
        state_n  = state;
        row_n    = row;
        bit_n    = bit_cnt;
        tmr_n    = tmr;
        shreg_n  = shreg;
        bright_n = bright_q;
        clk_n    = 1'b0;
        data_n   = 1'b0;
        latch_n  = 1'b0;
        aen_n    = 1'b0;
        addr_n   = addr_q;
        done_n   = 1'b0;
        case (state)
            S_IDLE: begin
                row_n  = '0;
                addr_n = '0;
                if (en) begin
                    state_n = S_SHIFT;
                    shreg_n = fb[0];
                    bit_n   = BIT_W'(COLS - 1);
                    tmr_n   = TMR_W'(SHIFT_TC);
                    data_n  = fb[0][COLS-1];
                end
            end
            S_SHIFT: begin
                if (tmr != '0) begin
                    tmr_n  = tmr - 1'b1;
                    data_n = shreg[COLS-1];
                    clk_n  = (int'(tmr_n) < DIV);
                end else if (bit_cnt != '0) begin
                    bit_n   = bit_cnt - 1'b1;
                    shreg_n = {shreg[COLS-2:0], 1'b0};
                    tmr_n   = TMR_W'(SHIFT_TC);
                    data_n  = shreg[COLS-2];
                end else begin
                    state_n = S_LATCH;
                    latch_n = 1'b1;
                    addr_n  = row;
                end
            end
            S_LATCH: begin
                state_n  = S_DISPLAY;
                bright_n = bright;
                tmr_n    = TMR_W'(DISP_TC);
                aen_n    = lit(tmr_n, bright);
            end
            S_DISPLAY: begin
                if (tmr != '0) begin
                    tmr_n = tmr - 1'b1;
                    aen_n = lit(tmr_n, bright_q);
                end else begin
                    done_n = (row == ADDR_W'(ROWS - 1));
                    row_n  = done_n ? '0 : row + 1'b1;
                    if (en) begin
                        state_n = S_SHIFT;
                        shreg_n = fb[row_n];
                        bit_n   = BIT_W'(COLS - 1);
                        tmr_n   = TMR_W'(SHIFT_TC);
                        data_n  = fb[row_n][COLS-1];
                    end else begin
                        state_n = S_IDLE;
                        row_n   = '0;
                        addr_n  = '0;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state    <= S_IDLE;
            row      <= '0;
            bit_cnt  <= '0;
            tmr      <= '0;
            shreg    <= '0;
            bright_q <= '0;
            clk_q    <= 1'b0;
            data_q   <= 1'b0;
            latch_q  <= 1'b0;
            aen_q    <= 1'b0;
            addr_q   <= '0;
            done_q   <= 1'b0;
            for (int i = 0; i < ROWS; i++) fb[i] <= '0;
        end else begin
            state    <= state_n;
            row      <= row_n;
            bit_cnt  <= bit_n;
            tmr      <= tmr_n;
            shreg    <= shreg_n;
            bright_q <= bright_n;
            clk_q    <= clk_n;
            data_q   <= data_n;
            latch_q  <= latch_n;
            aen_q    <= aen_n;
            addr_q   <= addr_n;
            done_q   <= done_n;
            // Shift register was loaded from the old contents this same edge.
            if (wr_en && int'(wr_row) < ROWS) fb[wr_row] <= wr_data;
        end
    end

    assign LDM_CLK     = clk_q;
    assign LDM_DATA    = data_q;
    assign LDM_LATCH   = latch_q;
    assign LDM_ADDR_EN = aen_q;
    assign LDM_ADDR    = addr_q;
    assign frame_done  = done_q;

endmodule

// File: tb/tb_ldm_scan_ctrl.sv
// Directed bench for ldm_scan_ctrl: a 16-row instance and a 12-row instance,
// each scan row captured over its 125-cycle period and compared to hand values.
module tb_ldm_scan_ctrl;

    logic        clk = 1'b0;
    logic        rstn, en16, en12, wr_en, sel;
    logic [3:0]  bright, wr_row;
    logic [15:0] wr_data;

    logic        a_clk, a_data, a_latch, a_aen, a_done;
    logic [3:0]  a_addr;
    logic        b_clk, b_data, b_latch, b_aen, b_done;
    logic [3:0]  b_addr;

    logic        o_clk, o_data, o_latch, o_aen, o_done;
    logic [3:0]  o_addr;

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] r_data;
    logic [3:0]  r_addr;
    int          r_rises, r_latch, r_lidx, r_en, r_done;

    always #5 clk = ~clk;

    ldm_scan_ctrl dut16 (
        .clk(clk), .rstn(rstn), .en(en16), .bright(bright),
        .wr_en(wr_en), .wr_row(wr_row), .wr_data(wr_data),
        .LDM_CLK(a_clk), .LDM_DATA(a_data), .LDM_LATCH(a_latch),
        .LDM_ADDR_EN(a_aen), .LDM_ADDR(a_addr), .frame_done(a_done)
    );

    ldm_scan_ctrl #(.ROWS(12)) dut12 (
        .clk(clk), .rstn(rstn), .en(en12), .bright(bright),
        .wr_en(wr_en), .wr_row(wr_row), .wr_data(wr_data),
        .LDM_CLK(b_clk), .LDM_DATA(b_data), .LDM_LATCH(b_latch),
        .LDM_ADDR_EN(b_aen), .LDM_ADDR(b_addr), .frame_done(b_done)
    );

    assign o_clk   = sel ? b_clk   : a_clk;
    assign o_data  = sel ? b_data  : a_data;
    assign o_latch = sel ? b_latch : a_latch;
    assign o_aen   = sel ? b_aen   : a_aen;
    assign o_addr  = sel ? b_addr  : a_addr;
    assign o_done  = sel ? b_done  : a_done;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [3:0] row, input logic [15:0] data);
        wr_en   = 1'b1;
        wr_row  = row;
        wr_data = data;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    // act 1: drop en16 at ev_at; act 2: write row 2 then out-of-range row 13.
    task automatic sample_row(input int act, input int ev_at);
        logic prev_clk;
        prev_clk = 1'b0;
        r_data = '0; r_addr = '0;
        r_rises = 0; r_latch = 0; r_lidx = -1; r_en = 0; r_done = 0;
        for (int i = 0; i < 125; i++) begin
            @(negedge clk);
            if (o_clk && !prev_clk) begin
                r_data = {r_data[14:0], o_data};
                r_rises++;
            end
            prev_clk = o_clk;
            if (o_latch) begin
                r_latch++;
                r_lidx = i;
            end
            if (o_aen) r_en++;
            if (o_done) r_done++;
            if (i == 124) r_addr = o_addr;
            if (act == 1 && i == ev_at) en16 = 1'b0;
            if (act == 2 && i == ev_at) begin
                wr_en = 1'b1; wr_row = 4'd2; wr_data = 16'hBEEF;
            end
            if (act == 2 && i == ev_at + 1) begin
                wr_row = 4'd13; wr_data = 16'hFFFF;
            end
            if (act == 2 && i == ev_at + 2) wr_en = 1'b0;
        end
    endtask

    task automatic check_row(input string p, input logic [15:0] d, input int e,
                             input logic [3:0] a, input int dn);
        chk({p, "_data"},  r_data,  d);
        chk({p, "_rises"}, r_rises, 16);
        chk({p, "_latch"}, r_latch, 1);
        chk({p, "_lidx"},  r_lidx,  64);
        chk({p, "_aen"},   r_en,    e);
        chk({p, "_addr"},  r_addr,  a);
        chk({p, "_done"},  r_done,  dn);
    endtask

    function automatic logic [15:0] exp16(input int r);
        return (r == 0) ? 16'hA5F0 : 16'(r * 16'h1111);
    endfunction

    initial begin
        rstn = 1'b0; en16 = 1'b0; en12 = 1'b0; sel = 1'b0;
        wr_en = 1'b0; wr_row = '0; wr_data = '0; bright = '0;
        repeat (3) @(negedge clk);
        chk("rst16_out", {a_clk, a_data, a_latch, a_aen, a_addr, a_done}, 0);
        chk("rst12_out", {b_clk, b_data, b_latch, b_aen, b_addr, b_done}, 0);
        rstn = 1'b1;
        for (int r = 0; r < 16; r++) wr(4'(r), exp16(r));

        // full frame with brightness variants, wrap, then en drop during row 3 shift
        en16 = 1'b1;
        for (int f = 0; f < 2; f++) begin
            for (int r = 0; r < (f == 0 ? 16 : 4); r++) begin
                int e;
                bright = (f == 0 && r == 1) ? 4'd5 : (f == 0 && r == 2) ? 4'd0 : 4'd15;
                e = (f == 0 && r == 1) ? 20 : (f == 0 && r == 2) ? 0 : 60;
                sample_row((f == 1 && r == 3) ? 1 : 0, 10);
                check_row($sformatf("f%0d_r%0d", f, r), exp16(r), e, 4'(r),
                          (f == 1 && r == 0) ? 1 : 0);
            end
        end
        repeat (5) begin
            @(negedge clk);
            chk("idle_out", {a_clk, a_data, a_latch, a_aen, a_addr, a_done}, 0);
        end

        // synchronous reset in the middle of a shift clears buffer and state
        en16 = 1'b1;
        repeat (10) @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        chk("rst_mid_out", {a_clk, a_data, a_latch, a_aen, a_addr, a_done}, 0);
        @(negedge clk);
        rstn = 1'b1;
        sample_row(0, 0);
        check_row("restart", 16'h0000, 60, 4'd0, 0);
        en16 = 1'b0;

        // 12-row instance: write during shift of the same row, out-of-range write
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        sel = 1'b1;
        wr(4'd2, 16'h1234);
        wr(4'd11, 16'h8001);
        en12 = 1'b1;
        for (int f = 0; f < 2; f++) begin
            for (int r = 0; r < (f == 0 ? 12 : 4); r++) begin
                logic [15:0] d;
                d = (r == 2) ? (f == 0 ? 16'h1234 : 16'hBEEF) : (r == 11) ? 16'h8001 : 16'h0000;
                sample_row((f == 0 && r == 2) ? 2 : 0, 10);
                check_row($sformatf("r12_f%0d_r%0d", f, r), d, 60, 4'(r),
                          (f == 1 && r == 0) ? 1 : 0);
            end
        end
        en12 = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
